// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped peripheral controller blocks.
package peripheral_pkg;

    localparam logic [3:0] KPD_DATA   = 4'd0;
    localparam logic [3:0] KPD_STATUS = 4'd1;
    localparam logic [3:0] KPD_CTRL   = 4'd2;

    localparam int KEY_CODE_W = 4;

    typedef enum logic {
        KPD_RELEASED = 1'b0,
        KPD_PRESSED  = 1'b1
    } kpd_state_e;

endpackage

// File: rtl/keypad_key_fifo.sv
// Small key-code FIFO; flush overrides push/pop, and a pop frees room for a same-cycle push.
module keypad_key_fifo
    import peripheral_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [KEY_CODE_W-1:0] din,
    output logic [KEY_CODE_W-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [3:0]            count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KEY_CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        ptr_inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == 4'd0);
    assign full    = (count == 4'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 4'd1;
            else if (!do_push && do_pop)
                count <= count - 4'd1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: row-by-row column sampling, whole-frame debounce,
// single-key encoding into a FIFO, and a small CPU register interface.
module keypad_scan_controller
    import peripheral_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    input  logic [3:0] address,
    input  logic [7:0] din,
    input  logic       writeEnable,
    input  logic       readEnable,
    output logic [7:0] dout,
    output logic       key_avail
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE_CNT + 1);

    logic [DIV_W-1:0]      div;
    logic [1:0]            row_idx;
    logic [15:0]           frame;
    logic [15:0]           frame_next;
    logic [15:0]           prev_frame;
    logic [STB_W-1:0]      stable_cnt;
    logic                  terminal;
    logic                  frame_done;
    logic                  frame_same;
    logic                  accept;
    kpd_state_e            state;
    kpd_state_e            state_next;
    logic                  push;
    logic [KEY_CODE_W-1:0] push_code;
    logic                  pop;
    logic                  flush;
    logic                  clr_ovf;
    logic                  ovf_set;
    logic                  overflow;
    logic [KEY_CODE_W-1:0] head_code;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [3:0]            fifo_count;

    function automatic logic is_one_hot(input logic [15:0] v);
        is_one_hot = (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Bit position 4*row+col doubles as the key code {row, col}.
    function automatic logic [KEY_CODE_W-1:0] bit_index(input logic [15:0] v);
        bit_index = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) bit_index = KEY_CODE_W'(i);
    endfunction

    assign terminal   = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_done = terminal && (row_idx == 2'd3);

    always_comb begin
        frame_next = frame;
        frame_next[{row_idx, 2'b00} +: 4] = cols;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            row_idx <= 2'd0;
            rows    <= 4'b0001;
            frame   <= 16'd0;
        end else if (terminal) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
            rows    <= {rows[2:0], rows[3]};
            frame   <= frame_next;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign frame_same = (frame_next == prev_frame);
    assign accept     = frame_done && frame_same && (stable_cnt == STB_W'(DEBOUNCE_CNT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_frame <= 16'd0;
            stable_cnt <= '0;
        end else if (frame_done) begin
            if (frame_same) begin
                if (stable_cnt != STB_W'(DEBOUNCE_CNT))
                    stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
                prev_frame <= frame_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= KPD_RELEASED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            KPD_RELEASED: if (accept && frame_next != 16'd0) state_next = KPD_PRESSED;
            KPD_PRESSED:  if (accept && frame_next == 16'd0) state_next = KPD_RELEASED;
            default:      state_next = KPD_RELEASED;
        endcase
    end

    // Rollover frames move to PRESSED without a push.
    always_comb begin
        push      = 1'b0;
        push_code = bit_index(frame_next);
        if (accept && state == KPD_RELEASED && is_one_hot(frame_next))
            push = 1'b1;
    end

    assign pop     = readEnable && (address == KPD_DATA);
    assign flush   = writeEnable && (address == KPD_CTRL) && din[0];
    assign clr_ovf = writeEnable && (address == KPD_STATUS) && din[7];
    assign ovf_set = push && fifo_full && !(pop && !fifo_empty) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  overflow <= 1'b0;
        else if (ovf_set)           overflow <= 1'b1;
        else if (flush || clr_ovf)  overflow <= 1'b0;
    end

    keypad_key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_code),
        .dout  (head_code),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign key_avail = !fifo_empty;

    always_comb begin
        dout = 8'h00;
        case (address)
            KPD_DATA:   if (!fifo_empty) dout = {1'b1, 3'b000, head_code};
            KPD_STATUS: dout = {overflow, 3'b000, state == KPD_PRESSED, fifo_count[2:0]};
            default:    dout = 8'h00;
        endcase
    end

endmodule
